// File: rtl/uart_pkg.sv
// Shared constants for the UART register-port arbiter: register map,
// sequencer state encoding and the UART write polarity.
package uart_pkg;

  localparam logic [1:0] TX_DATA_ADDR  = 2'd0;
  localparam logic [1:0] RX_DATA_ADDR  = 2'd1;
  localparam logic [1:0] FREQ_DIV_ADDR = 2'd2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic UART_WE_WRITE = 1'b0;

  // Requesters use 1 = write; the UART uses 0 = write.
  function automatic logic to_uart_we(input logic we);
    return we ? UART_WE_WRITE : ~UART_WE_WRITE;
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// One requester channel: single-byte read/write request with a done pulse.
interface uart_bus_arbiter_if;
  logic       valid;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  modport master (output valid, we, addr, wdata, input  done, rdata, err);
  modport slave  (input  valid, we, addr, wdata, output done, rdata, err);
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin picker; a tie goes to the requester
// that was not granted last.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    grant = (valid0 && valid1) ? ~last_grant : valid1;
    any   = valid0 | valid1;
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter for two requesters in front of the UART register port,
// sequencing the strobe/ack four-phase handshake with a per-edge timeout.
module uart_bus_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_bus_arbiter_if.slave    req0,
  uart_bus_arbiter_if.slave    req1,
  output logic [1:0]           uart_addr,
  output logic [7:0]           uart_wdata,
  input  logic [7:0]           uart_rdata,
  output logic                 uart_we,
  output logic                 uart_stb,
  output logic                 uart_clk,
  input  logic                 uart_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       uart_addr_q, uart_addr_d;
  logic [7:0]       uart_wdata_q, uart_wdata_d;
  logic             uart_we_q, uart_we_d;
  logic             uart_stb_q, uart_stb_d;
  logic             uart_clk_q, uart_clk_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][7:0]  rdata_q, rdata_d;

  logic             arb_grant;
  logic             arb_any;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_expired;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0.valid),
    .valid1     (req1.valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign cnt_expired = (cnt_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every signal takes its hold value first, so no branch can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    uart_addr_d  = uart_addr_q;
    uart_wdata_d = uart_wdata_q;
    uart_we_d    = uart_we_q;
    uart_stb_d   = uart_stb_q;
    uart_clk_d   = uart_clk_q;
    done_d       = done_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d      = arb_grant;
          we_d         = arb_grant ? req1.we    : req0.we;
          uart_addr_d  = arb_grant ? req1.addr  : req0.addr;
          uart_wdata_d = arb_grant ? req1.wdata : req0.wdata;
          uart_we_d    = to_uart_we(we_d);
          uart_stb_d   = 1'b1;
          uart_clk_d   = 1'b1;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (uart_ack) begin
          if (!we_q) rdata_d[grant_q] = uart_rdata;
          uart_stb_d = 1'b0;
          uart_clk_d = 1'b0;
          cnt_d      = '0;
          state_d    = RELEASE;
        end else if (cnt_expired) begin
          err_d[grant_q]  = 1'b1;
          done_d[grant_q] = 1'b1;
          uart_stb_d      = 1'b0;
          uart_clk_d      = 1'b0;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RELEASE: begin
        if (!uart_ack) begin
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end else if (cnt_expired) begin
          err_d[grant_q]  = 1'b1;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        done_d       = '0;
        err_d        = '0;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      uart_addr_q  <= '0;
      uart_wdata_q <= '0;
      uart_we_q    <= 1'b0;
      uart_stb_q   <= 1'b0;
      uart_clk_q   <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking updates make every flop load from the same pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      uart_addr_q  <= uart_addr_d;
      uart_wdata_q <= uart_wdata_d;
      uart_we_q    <= uart_we_d;
      uart_stb_q   <= uart_stb_d;
      uart_clk_q   <= uart_clk_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign uart_addr  = uart_addr_q;
  assign uart_wdata = uart_wdata_q;
  assign uart_we    = uart_we_q;
  assign uart_stb   = uart_stb_q;
  assign uart_clk   = uart_clk_q;

  assign req0.done  = done_q[0];
  assign req0.rdata = rdata_q[0];
  assign req0.err   = err_q[0];
  assign req1.done  = done_q[1];
  assign req1.rdata = rdata_q[1];
  assign req1.err   = err_q[1];

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
Two-requester round-robin arbiter and bus sequencer in front of the UART's register port (TX data 0x0, RX data 0x1, freq divider 0x2). Each requester issues single byte read/write transactions with a simple valid/done handshake. The arbiter drives the UART's strobe/clock/ack four-phase handshake and translates the write polarity. Each transaction carries a timeout, so a hung UART cannot lock out either requester.

Parameters:
TIMEOUT, 255, max cycles spent waiting for each ack edge (assert or release) before aborting; legal range 1..255.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  single system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 transaction request; held until req0_done
req0_we  in  1  1 = write, 0 = read
req0_addr  in  2  UART register address
req0_wdata  in  8  write data
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  8  read data, valid while req0_done=1
req0_err  out  1  timeout flag, valid while req0_done=1
req1_valid, req1_we, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: identical to requester 0
uart_addr  out  2  to UART wb_addr
uart_wdata  out  8  to UART wb_data_in
uart_rdata  in  8  from UART wb_data_out
uart_we  out  1  UART convention: 0 = write, 1 = read
uart_stb  out  1  to UART wb_stb
uart_clk  out  1  to UART wb_clk (transaction phase strobe)
uart_ack  in  1  from UART wb_ack

Behaviour:
- All outputs are registered. While reset=0, every output is 0 and the state is IDLE. last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - If exactly one valid is set, grant that requester. If both are set, grant the requester that is not last_grant.
  - Latch addr, wdata and we. Drive uart_we = ~we.
  - Set uart_stb=1, uart_clk=1, clear the timeout counter, go to ISSUE.
- ISSUE:
  - On uart_ack=1: capture uart_rdata into the granted requester's rdata register. Set uart_clk=0 and uart_stb=0, clear the counter, go to RELEASE.
  - If the counter reaches TIMEOUT first: set err, drop uart_stb and uart_clk, go to DONE.
- RELEASE:
  - On uart_ack=0: go to DONE.
  - If the counter reaches TIMEOUT first: set err, go to DONE.
- DONE:
  - Pulse reqN_done for the granted requester only, together with rdata and err. rdata is captured on reads; on writes it holds its previous value.
  - Update last_grant to the granted requester, clear err, go to IDLE.
- Nominal latency, measured against the UART's one-cycle ack response: valid sampled at edge E0, uart_stb/uart_clk high from E1, ack seen at E3, ack low seen at E5, done high for the cycle after E5. The next grant can be sampled in IDLE two edges after DONE is entered.
- Requester rules:
  - The requester drops valid on the edge where it samples done.
  - If valid is deasserted mid-transaction, the transaction still completes and done still pulses.
  - Changing addr/wdata/we after grant has no effect; they were latched at grant.
- Ungranted requester: its done stays 0 and its rdata holds.
- Timeout counter: saturating, CNT_W bits, increments every cycle in ISSUE and RELEASE.
- The read-pop side effect in the UART occurs exactly once per granted read, including reads that later time out in RELEASE.
- Asynchronous reset mid-transaction:
  - Outputs clear immediately and no done is issued.
  - uart_clk=0 lets a UART parked in its ack state return to idle.
  - After reset releases, any pending valid is re-arbitrated from last_grant=1.

Decomposition:
- Shared package uart_pkg:
  - UART register address constants TX_DATA_ADDR=0, RX_DATA_ADDR=1, FREQ_DIV_ADDR=2.
  - Arbiter state encoding IDLE/ISSUE/RELEASE/DONE.
  - UART write-polarity constant UART_WE_WRITE=0.
- One natural sub-module, rr_arb2: combinational two-input round-robin picker (valid0, valid1, last_grant -> grant, any). The FSM, latches and timeout counter stay in uart_bus_arbiter.

Test Plan:
- Write: req0 write 0x41 to addr 0 against a UART model → uart_we=0, uart_wdata=0x41, uart_addr=0; req0_done pulses 1 cycle on the 6th edge; err=0; req1_done stays 0.
- Read: UART model returns 0x5A at addr 1, req1 read → uart_we=1, req1_rdata=0x5A with req1_done, exactly one ack cycle.
- Contention: both valid held continuously with requesters re-asserting after done → grants alternate 0,1,0,1 over 4 transactions; the first grant goes to req0 after reset.
- Timeout: UART model never acks, TIMEOUT=4 → uart_stb high for 5 cycles, then dropped; done with err=1. A following normal transaction completes with err=0.
- Reset mid-transaction: reset low while in RELEASE → uart_stb, uart_clk and all done signals go 0 without a clock edge. After release, a still-valid req1 is granted and completes normally.
- Back-to-back: req0 issues writes to addr 2 (0x06) then addr 0 (0x55) with req1 idle → both granted to req0 in order, no idle gap beyond the specified DONE→IDLE→ISSUE sequence.
